// File: rtl/reg_scoreboard_pkg.sv
// Shared constants, FSM encoding and register-index helpers for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 3;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_e;

  // One-hot register mask; x0 is hardwired so it never maps to a tracked bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    if (idx != {REG_W{1'b0}}) begin
      mask[idx] = 1'b1;
    end else begin
      mask = {NUM_REGS{1'b0}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard_hazard.sv
// Combinational RAW/WAW check of an issuing instruction against the pending-write bitmap.
module sb_hazard_check
  import reg_scoreboard_pkg::*;
(
  input  logic [REG_W-1:0]    rs1,
  input  logic                rs1_use,
  input  logic [REG_W-1:0]    rs2,
  input  logic                rs2_use,
  input  logic [REG_W-1:0]    rd,
  input  logic                rdwr,
  input  logic [NUM_REGS-1:0] busy,
  input  logic [NUM_REGS-1:0] bypass_mask,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy_eff_s;
  logic                rs1_hit_s;
  logic                rs2_hit_s;
  logic                rd_hit_s;

  assign busy_eff_s = busy & ~bypass_mask;

  // reg_onehot yields an empty mask for x0, so x0 operands never stall.
  always_comb begin
    rs1_hit_s = rs1_use & (|(busy_eff_s & reg_onehot(rs1)));
    rs2_hit_s = rs2_use & (|(busy_eff_s & reg_onehot(rs2)));
    rd_hit_s  = rdwr    & (|(busy_eff_s & reg_onehot(rd)));
    hazard    = rs1_hit_s | rs2_hit_s | rd_hit_s;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: pending-write bitmap, in-flight writer count and flush-drain FSM.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle writeback release hazards and the writer limit.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [REG_W-1:0]    issue_rs1_i,
  input  logic                issue_rs1_use_i,
  input  logic [REG_W-1:0]    issue_rs2_i,
  input  logic                issue_rs2_use_i,
  input  logic [REG_W-1:0]    issue_rd_i,
  input  logic                issue_rdwr_i,
  input  logic                wb_rdvalid_i,
  input  logic [REG_W-1:0]    wb_rdnum_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [CNT_W-1:0]    inflight_o,
  output logic                drain_done_o,
  output logic                err_o
);

  sb_state_e           state_r;
  sb_state_e           state_nxt_s;
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [CNT_W-1:0]    cnt_eff_s;
  logic [NUM_REGS-1:0] bypass_mask_s;
  logic                err_r;
  logic                drain_done_r;
  logic                hazard_s;
  logic                full_s;
  logic                inc_s;
  logic                dec_s;
  logic                underflow_s;
  logic                drain_exit_s;

`ifdef SCOREBOARD_BYPASS_EN
  assign bypass_mask_s = wb_rdvalid_i ? reg_onehot(wb_rdnum_i) : {NUM_REGS{1'b0}};
  assign cnt_eff_s     = (wb_rdvalid_i && (cnt_r != {CNT_W{1'b0}})) ? (cnt_r - CNT_W'(1)) : cnt_r;
`else
  assign bypass_mask_s = {NUM_REGS{1'b0}};
  assign cnt_eff_s     = cnt_r;
`endif

  sb_hazard_check u_hazard (
    .rs1         (issue_rs1_i),
    .rs1_use     (issue_rs1_use_i),
    .rs2         (issue_rs2_i),
    .rs2_use     (issue_rs2_use_i),
    .rd          (issue_rd_i),
    .rdwr        (issue_rdwr_i),
    .busy        (busy_r),
    .bypass_mask (bypass_mask_s),
    .hazard      (hazard_s)
  );

  assign full_s        = issue_rdwr_i & (cnt_eff_s == CNT_W'(MAX_INFLIGHT));
  assign issue_ready_o = ~rst & (state_r == SB_RUN) & ~flush_i & ~hazard_s & ~full_s;
  assign inc_s         = issue_valid_i & issue_ready_o & issue_rdwr_i;
  assign dec_s         = wb_rdvalid_i;

  // In-flight counter: a simultaneous accept and writeback cancel out; a lone underflow saturates at zero.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    underflow_s = 1'b0;
    case ({inc_s, dec_s})
      2'b10: cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          underflow_s = 1'b1;
          cnt_nxt_s   = cnt_r;
        end else begin
          underflow_s = 1'b0;
          cnt_nxt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Flush FSM: drain completes on the cycle whose next count reaches zero.
  always_comb begin
    state_nxt_s  = state_r;
    drain_exit_s = 1'b0;
    case (state_r)
      SB_RUN: begin
        if (flush_i) begin
          state_nxt_s = SB_DRAIN;
        end else begin
          state_nxt_s = SB_RUN;
        end
      end
      SB_DRAIN: begin
        if (cnt_nxt_s == {CNT_W{1'b0}}) begin
          state_nxt_s  = SB_RUN;
          drain_exit_s = 1'b1;
        end else begin
          state_nxt_s  = SB_DRAIN;
        end
      end
      default: state_nxt_s = SB_RUN;
    endcase
  end

  // Busy bitmap: clear on writeback, then set on accept so a same-register set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (dec_s) begin
      busy_nxt_s = busy_nxt_s & ~reg_onehot(wb_rdnum_i);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (inc_s) begin
      busy_nxt_s = busy_nxt_s | reg_onehot(issue_rd_i);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (drain_exit_s) begin
      busy_nxt_s = {NUM_REGS{1'b0}};
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // State, counter, bitmap and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SB_RUN;
      busy_r       <= {NUM_REGS{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
      drain_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= busy_nxt_s;
      cnt_r        <= cnt_nxt_s;
      err_r        <= err_r | underflow_s;
      drain_done_r <= drain_exit_s;
    end
  end

  assign busy_o       = busy_r;
  assign inflight_o   = cnt_r;
  assign drain_done_o = drain_done_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference model feeds an expected-state queue each cycle.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [REG_W-1:0]    issue_rs1_i;
  logic                issue_rs1_use_i;
  logic [REG_W-1:0]    issue_rs2_i;
  logic                issue_rs2_use_i;
  logic [REG_W-1:0]    issue_rd_i;
  logic                issue_rdwr_i;
  logic                wb_rdvalid_i;
  logic [REG_W-1:0]    wb_rdnum_i;
  logic                flush_i;
  logic [NUM_REGS-1:0] busy_o;
  logic [CNT_W-1:0]    inflight_o;
  logic                drain_done_o;
  logic                err_o;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs1_use_i (issue_rs1_use_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_rs2_use_i (issue_rs2_use_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rdwr_i    (issue_rdwr_i),
    .wb_rdvalid_i    (wb_rdvalid_i),
    .wb_rdnum_i      (wb_rdnum_i),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .inflight_o      (inflight_o),
    .drain_done_o    (drain_done_o),
    .err_o           (err_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_busy  = 32'd0;
  int          m_cnt   = 0;
  bit          m_err   = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_done  = 1'b0;

  typedef struct {
    logic [31:0] busy;
    int          cnt;
    bit          err;
    bit          done;
  } exp_t;

  exp_t exp_q[$];

  // One clock cycle: drive at negedge, check ready before the edge, check state after it.
  task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                      input int rdn, input bit wr, input bit wb, input int wbn, input bit fl);
    exp_t        e;
    logic [31:0] bv;
    bit          haz, full, rdy, acc;
    int          eff, n;
    issue_valid_i   = v;
    issue_rs1_i     = REG_W'(r1);
    issue_rs1_use_i = u1;
    issue_rs2_i     = REG_W'(r2);
    issue_rs2_use_i = u2;
    issue_rd_i      = REG_W'(rdn);
    issue_rdwr_i    = wr;
    wb_rdvalid_i    = wb;
    wb_rdnum_i      = REG_W'(wbn);
    flush_i         = fl;
    #1;
    bv  = m_busy;
    eff = m_cnt;
`ifdef SCOREBOARD_BYPASS_EN
    if (wb) bv[wbn] = 1'b0;
    if (wb && m_cnt > 0) eff = m_cnt - 1;
`endif
    haz  = (u1 && r1 != 0 && bv[r1]) || (u2 && r2 != 0 && bv[r2]) || (wr && rdn != 0 && bv[rdn]);
    full = wr && (eff >= MAX_INFLIGHT);
    rdy  = !rst && !m_drain && !fl && !haz && !full;
    check_val("ready", {31'd0, issue_ready_o}, {31'd0, rdy});
    acc = v && rdy;
    if (rst) begin
      m_busy = 32'd0; m_cnt = 0; m_err = 1'b0; m_drain = 1'b0; m_done = 1'b0;
    end else begin
      n = m_cnt + ((acc && wr) ? 1 : 0) - (wb ? 1 : 0);
      if (n < 0) begin
        n     = 0;
        m_err = 1'b1;
      end
      if (wb && wbn != 0) m_busy[wbn] = 1'b0;
      if (acc && wr && rdn != 0) m_busy[rdn] = 1'b1;
      m_cnt  = n;
      m_done = 1'b0;
      if (m_drain) begin
        if (n == 0) begin
          m_drain = 1'b0;
          m_busy  = 32'd0;
          m_done  = 1'b1;
        end
      end else if (fl) begin
        m_drain = 1'b1;
      end
    end
    e.busy = m_busy; e.cnt = m_cnt; e.err = m_err; e.done = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("busy", busy_o, e.busy);
      check_val("inflight", {29'd0, inflight_o}, 32'(e.cnt));
      check_val("err", {31'd0, err_o}, {31'd0, e.err});
      check_val("drain_done", {31'd0, drain_done_o}, {31'd0, e.done});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wback(input int r);
    step(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    idle();
    idle();
    check_val("rst_busy", busy_o, 32'd0);
    check_val("rst_inflight", {29'd0, inflight_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;

    // First writer to x5, then RAW against it
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    check_val("busy5_set", {31'd0, busy_o[5]}, 32'd1);
    check_val("inflight_one", {29'd0, inflight_o}, 32'd1);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    check_val("busy5_clr", {31'd0, busy_o[5]}, 32'd0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

    // x0 destination counts but is not tracked; x0 sources never stall
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_val("x0_busy", busy_o, 32'd0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    wback(0);

    // Writer limit
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 0, i, 1, 0, 0, 0);
    check_val("inflight_full", {29'd0, inflight_o}, 32'd4);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 6, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    check_val("busy_after_limit", busy_o, 32'h0000_005C);

    // Flush and drain
    wback(2);
    wback(3);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 7, 1, 1, 4, 0);
    step(1, 0, 0, 0, 0, 7, 1, 1, 6, 0);
    check_val("drain_pulse", {31'd0, drain_done_o}, 32'd1);
    idle();
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    wback(7);

    // Underflow is sticky until reset
    wback(3);
    check_val("err_set", {31'd0, err_o}, 32'd1);
    idle();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;

    // Reset in the middle of a drain
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_val("rst_drain_done", {31'd0, drain_done_o}, 32'd0);
    step(1, 9, 1, 0, 0, 9, 1, 0, 0, 0);

    // Random traffic over a small register window to provoke hazards
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
           ($urandom_range(0, 24) == 0));
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
